// File: rtl/seg7_pkg.sv
// +-----------------------------------------------------------------------+
// | seg7_pkg : shared types, segment table and width helper for seg7_*   |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// +-----------------------------------------------------------------------+
// | seg7_hex_decode : nibble to active-high seven-segment pattern        |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// +-----------------------------------------------------------------------+
// | seg7_scan_driver : time-multiplexed hex display scanner with dead gap |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SLOT_CYCLES    = 50000,
  parameter int GAP_CYCLES     = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                load,
  input  logic [4*NUM_DIGITS-1:0]             data_in,
  input  logic [NUM_DIGITS-1:0]               dp_in,
  input  logic                                blank_lz,
  output logic [7:0]                          seg_led,
  output logic [NUM_DIGITS-1:0]               dig_sel,
  output logic [idx_width(NUM_DIGITS)-1:0]    slot_idx
);

  localparam int IDX_W   = idx_width(NUM_DIGITS);
  localparam int CNT_MAX = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [IDX_W-1:0]        idx_nx, idx_inc;
  logic                    enter;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    all_zero;
  logic [6:0]              dec_seg;
  logic                    blank;
  logic [7:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   dig_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else if (load) begin
      shadow_data <= data_in;
      shadow_dp   <= dp_in;
    end
  end

  assign idx_inc = (slot_idx == IDX_LAST) ? '0 : slot_idx + 1'b1;

  always_comb begin
    state_nx = state;
    idx_nx   = slot_idx;
    cnt_nx   = cnt;
    enter    = 1'b0;
    if (!en) begin
      state_nx = ST_OFF;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nx = ST_DRIVE;
          idx_nx   = '0;
          cnt_nx   = '0;
          enter    = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx = '0;
            if (GAP_CYCLES == 0) begin
              idx_nx = idx_inc;
              enter  = 1'b1;
            end else begin
              state_nx = ST_GAP;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nx = ST_DRIVE;
            cnt_nx   = '0;
            idx_nx   = idx_inc;
            enter    = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = ST_OFF;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 of the shadow are all zero.
  always_comb begin
    all_zero  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]       = shadow_data[4*i +: 4];
      all_zero     = all_zero && (nib[i] == 4'h0);
      zero_from[i] = all_zero;
    end
  end

  seg7_hex_decode u_decode (
    .nibble (nib[idx_nx]),
    .seg    (dec_seg)
  );

  assign blank = blank_lz && (idx_nx != '0) && zero_from[idx_nx];

  // Segments are only refreshed on DRIVE entry so a slot never changes mid-way.
  always_comb begin
    seg_nx = 8'h00;
    dig_nx = '0;
    if (enter) begin
      seg_nx = {shadow_dp[idx_nx], blank ? 7'h00 : dec_seg};
    end else if (state_nx == ST_DRIVE) begin
      seg_nx = seg_led ^ SEG_INV;
    end
    if (state_nx == ST_DRIVE) begin
      dig_nx = NUM_DIGITS'(1) << idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      slot_idx <= '0;
      cnt      <= '0;
      seg_led  <= SEG_INV;
      dig_sel  <= DIG_INV;
    end else begin
      state    <= state_nx;
      slot_idx <= idx_nx;
      cnt      <= cnt_nx;
      seg_led  <= seg_nx ^ SEG_INV;
      dig_sel  <= dig_nx ^ DIG_INV;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// +-----------------------------------------------------------------------+
// | tb_seg7_scan_driver : scoreboard bench, two polarity/gap variants    |
// | Rev 1.0                                                              |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int S0 = 4;
  localparam int G0 = 1;
  localparam int S1 = 3;
  localparam int G1 = 0;

  logic           clk = 1'b0;
  logic           rst, en, load, blank_lz;
  logic [4*N-1:0] data_in;
  logic [N-1:0]   dp_in;
  logic [7:0]     seg0, seg1;
  logic [N-1:0]   dig0, dig1;
  logic [1:0]     idx0, idx1;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYCLES(S0), .GAP_CYCLES(G0),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_led(seg0), .dig_sel(dig0),
    .slot_idx(idx0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYCLES(S1), .GAP_CYCLES(G1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_led(seg1), .dig_sel(dig1),
    .slot_idx(idx1)
  );

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] dig;
    logic [1:0]   idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  logic [6:0] ref_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference view: time since enable determines digit and in-slot position.
  logic [4*N-1:0] m_data = '0;
  logic [N-1:0]   m_dp   = '0;
  int             t [2];
  bit             running [2];
  logic [7:0]     latched [2];

  function automatic logic [7:0] pattern(int d, bit blz);
    bit         all_zero;
    logic [3:0] nb;
    all_zero = 1'b1;
    for (int k = d; k < N; k++) if (m_data[4*k +: 4] != 4'h0) all_zero = 1'b0;
    nb = m_data[4*d +: 4];
    return {m_dp[d], (blz && d > 0 && all_zero) ? 7'h00 : ref_seg[nb]};
  endfunction

  task automatic step();
    exp_t         e;
    int           slot, sl, d, w;
    bit           act;
    logic [7:0]   si;
    logic [N-1:0] di;
    for (int k = 0; k < 2; k++) begin
      slot = (k == 0) ? S0 + G0 : S1 + G1;
      sl   = (k == 0) ? S0 : S1;
      si   = (k == 0) ? 8'h00 : 8'hFF;
      di   = (k == 0) ? '0 : '1;
      act  = 1'b0;
      d    = 0;
      if (rst || !en) begin
        running[k] = 1'b0;
        t[k]       = 0;
      end else begin
        t[k]       = running[k] ? t[k] + 1 : 0;
        running[k] = 1'b1;
        d = (t[k] % (N * slot)) / slot;
        w = t[k] % slot;
        if (w == 0) latched[k] = pattern(d, blank_lz);
        act = (w < sl);
      end
      e.seg = (act ? latched[k] : 8'h00) ^ si;
      e.dig = (act ? (N'(1) << d) : N'(0)) ^ di;
      e.idx = 2'(d);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (rst) begin
      m_data = '0;
      m_dp   = '0;
    end else if (load) begin
      m_data = data_in;
      m_dp   = dp_in;
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  task automatic compare(int inst, exp_t e, logic [7:0] s, logic [N-1:0] dg, logic [1:0] ix);
    checks++;
    if (s !== e.seg || dg !== e.dig || ix !== e.idx) begin
      errors++;
      $display("FAIL scan%0d cycle %0d: got seg=%h dig=%b idx=%0d, expected seg=%h dig=%b idx=%0d",
               inst, cycle, s, dg, ix, e.seg, e.dig, e.idx);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      while (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, seg0, dig0, idx0);
      end
      while (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, seg1, dig1, idx1);
      end
    end
  end

  initial begin : stimulus
    running[0] = 1'b0; running[1] = 1'b0;
    t[0] = 0; t[1] = 0;
    latched[0] = '0; latched[1] = '0;
    rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0;
    data_in = '0; dp_in = '0;
    tick(2);
    rst = 1'b0;
    tick(1);

    data_in = 16'h1234; load = 1'b1; tick(1); load = 1'b0;
    en = 1'b1;
    tick(45);

    data_in = 16'hABCD; dp_in = 4'b0100; load = 1'b1; tick(1); load = 1'b0;
    tick(40);

    // Resynchronise, then load while digit 1 is being driven.
    en = 1'b0; tick(1);
    data_in = 16'h1234; dp_in = 4'b0000; load = 1'b1; tick(1); load = 1'b0;
    en = 1'b1; tick(7);
    data_in = 16'h5678; load = 1'b1; tick(1); load = 1'b0;
    tick(20);

    data_in = 16'h0050; blank_lz = 1'b1; load = 1'b1; tick(1); load = 1'b0;
    tick(45);

    en = 1'b0; tick(2); en = 1'b1; tick(30);
    tick(12);
    rst = 1'b1; tick(1); rst = 1'b0; tick(25);

    data_in = 16'h0008; blank_lz = 1'b0; load = 1'b1; tick(1); load = 1'b0;
    tick(30);

    for (int i = 0; i < 400; i++) begin
      load     = ($urandom % 8 == 0);
      data_in  = 16'($urandom) >> $urandom_range(0, 15);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      en       = ($urandom % 40 != 0);
      rst      = ($urandom % 150 == 0);
      tick(1);
    end
    rst = 1'b0; load = 1'b0;
    tick(1);

    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
